hamming_sipo_decoder: RTL and testbench
=======================================

// Module: hamming_sipo_decoder
// PURPOSE
//  Receive-side stage directly downstream of the 7-bit PISO serializer.
//  Shifts in the serial Hamming(7,4) stream, frames it into 7-bit codewords,
//  computes the syndrome, corrects any single-bit error, and presents a
//  registered 4-bit data word with a one-cycle valid strobe.
// PARAMETERS
//  CODE_W     7  codeword width; only 7 is supported (elaboration error otherwise)
//  LSB_FIRST  1  1: first serial bit -> codeword[0]; 0: first bit -> codeword[CODE_W-1]
//  CORRECT_EN 1  1: flip the bit the syndrome points to; 0: detect and flag only
// PORTS
//  clk             in   1        rising-edge clock, same domain as the serializer
//  rst             in   1        asynchronous, active-high reset
//  serial_in       in   1        serial codeword bit
//  bit_valid       in   1        serial_in is sampled only when high
//  frame_start     in   1        qualified by bit_valid; marks bit 0 of a word
//  codeword_out    out  CODE_W   received codeword, pre-correction
//  data_out        out  4        corrected data {d3,d2,d1,d0}
//  syndrome        out  3        error position 1..7; 0 means no error
//  error_corrected out  1        syndrome!=0 and CORRECT_EN=1
//  word_valid      out  1        one-cycle strobe; outputs above are valid with it
//  resync          out  1        one-cycle pulse: a partial word was discarded
// BEHAVIOUR
//  Reset: all outputs 0, bit counter 0, shift register 0, FSM = IDLE.
//  Bit map (position p = bit p-1): parity in p1,p2,p4 (bits 0,1,3);
//   data d0..d3 in p3,p5,p6,p7 (bits 2,4,5,6).
//  s0=^bits{0,2,4,6}; s1=^bits{1,2,5,6}; s2=^bits{3,4,5,6}; syndrome={s2,s1,s0}.
//  FSM IDLE: bits are ignored until bit_valid&frame_start. That bit is bit 0,
//   counter becomes 1, and the FSM moves to RECV.
//  FSM RECV: each bit_valid shifts one bit in and increments the counter.
//   - When the 7th bit is accepted (cycle N), the codeword is captured into the
//     decode register and the counter returns to 0. The FSM stays in RECV.
//   - The next valid bit starts the next word, with or without frame_start
//     (back-to-back streaming).
//  Latency: the registered syndrome, data_out, error_corrected and word_valid=1
//   appear at cycle N+1. The outputs hold their values until the next word.
//   word_valid is high for exactly one cycle.
//  Gaps: bit_valid low -> counter and shift register hold; there is no timeout.
//  frame_start with bit_valid while counter is 1..6:
//   - The partial word is dropped and resync pulses at the next cycle.
//   - The bit is taken as bit 0 of a new word; no word_valid for the dropped word.
//  frame_start with bit_valid at counter 0: normal word start, no resync.
//  frame_start without bit_valid: ignored.
//  Reset mid-word: the partial word is discarded and word_valid is not raised.
//  Simultaneous 7th bit and frame_start: frame_start has priority.
//   The partial word is dropped, resync pulses, and no word_valid.
//  Single-error correction only. A double error gives a wrong correction;
//   no double-error detection is provided.
// STRUCTURE
//  Shared package hamming_pkg holds:
//   - CODE_W=7, DATA_W=4 and the parity-bit indices;
//   - the function hamming74_syndrome(codeword) -> [2:0], shared with the encoder;
//   - the function hamming74_extract(codeword) -> [3:0].
//  One sub-module, hamming74_correct: combinational syndrome + bit flip between
//   the capture register and the output register.
//  Top level: FSM, 3-bit counter, shift register, output register.
// TESTING
//  1 Reset, then frame_start + bits of 7'h55 (LSB first)
//     -> word_valid at N+1, data_out=4'hB, syndrome=0, error_corrected=0.
//  2 7'h45 (bit 4 flipped from 7'h55) -> syndrome=5, data_out=4'hB,
//     error_corrected=1, codeword_out=7'h45.
//  3 Three back-to-back words (21 consecutive valid bits, one frame_start)
//     -> word_valid pulses 7 cycles apart, no resync.
//  4 frame_start after 3 bits -> resync pulse, no word_valid for the fragment;
//     the following 7 bits decode correctly.
//  5 bit_valid low for 5 cycles mid-word -> same result as an uninterrupted word.
//  6 rst asserted after 4 bits (asynchronous, mid-cycle) -> outputs 0 at once;
//     bits before the next frame_start are ignored.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions used by the receive-side decoder (and the
// transmit-side encoder).
//   CODE_W / DATA_W : codeword and data widths
//   *_IDX           : bit index of each parity/data bit inside a codeword
//   hamming74_syndrome(cw) : 3-bit syndrome {s2,s1,s0}, 0 = no error
//   hamming74_extract(cw)  : data word {d3,d2,d1,d0}
package hamming_pkg;

    localparam int unsigned CODE_W = 7;
    localparam int unsigned DATA_W = 4;

    // Position p of the classic Hamming layout lives at bit p-1.
    localparam int unsigned P1_IDX = 0;
    localparam int unsigned P2_IDX = 1;
    localparam int unsigned D0_IDX = 2;
    localparam int unsigned P4_IDX = 3;
    localparam int unsigned D1_IDX = 4;
    localparam int unsigned D2_IDX = 5;
    localparam int unsigned D3_IDX = 6;

    function automatic logic [2:0] hamming74_syndrome(input logic [CODE_W-1:0] cw);
        logic s0;
        logic s1;
        logic s2;
        s0 = cw[P1_IDX] ^ cw[D0_IDX] ^ cw[D1_IDX] ^ cw[D3_IDX];
        s1 = cw[P2_IDX] ^ cw[D0_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX];
        s2 = cw[P4_IDX] ^ cw[D1_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX];
        return {s2, s1, s0};
    endfunction

    function automatic logic [DATA_W-1:0] hamming74_extract(input logic [CODE_W-1:0] cw);
        return {cw[D3_IDX], cw[D2_IDX], cw[D1_IDX], cw[D0_IDX]};
    endfunction

endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) syndrome computation and single-bit correction.
// Ports:
//   codeword_i        : received codeword
//   data_o            : data word, corrected when CORRECT_EN=1
//   syndrome_o        : error position 1..7, 0 = no error
//   error_corrected_o : a non-zero syndrome was seen and correction is enabled
module hamming74_correct
    import hamming_pkg::*;
#(
    parameter bit CORRECT_EN = 1'b1
) (
    input  logic [CODE_W-1:0] codeword_i,
    output logic [DATA_W-1:0] data_o,
    output logic [2:0]        syndrome_o,
    output logic              error_corrected_o
);

    logic [CODE_W-1:0] flip;
    logic [CODE_W-1:0] fixed;

    always_comb begin
        syndrome_o = hamming74_syndrome(codeword_i);
        // Syndrome value p selects bit p-1; zero selects nothing.
        flip = '0;
        for (int unsigned i = 0; i < CODE_W; i++) begin
            flip[i] = (syndrome_o == 3'(i + 1));
        end
        fixed             = CORRECT_EN ? (codeword_i ^ flip) : codeword_i;
        data_o            = hamming74_extract(fixed);
        error_corrected_o = CORRECT_EN && (syndrome_o != 3'd0);
    end

endmodule

// File: rtl/hamming_sipo_decoder.sv
// Serial-in Hamming(7,4) receiver: frames the serial stream into codewords,
// corrects single-bit errors and presents a registered data word.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   serial_in       : serial codeword bit, sampled when bit_valid is high
//   bit_valid       : qualifies serial_in and frame_start
//   frame_start     : marks bit 0 of a word
//   codeword_out    : received codeword before correction
//   data_out        : corrected data {d3,d2,d1,d0}
//   syndrome        : error position 1..7, 0 = clean
//   error_corrected : non-zero syndrome with correction enabled
//   word_valid      : one-cycle strobe, outputs above valid with it
//   resync          : one-cycle pulse, a partial word was discarded
module hamming_sipo_decoder #(
    parameter int unsigned CODE_W     = 7,
    parameter bit          LSB_FIRST  = 1'b1,
    parameter bit          CORRECT_EN = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           serial_in,
    input  logic                           bit_valid,
    input  logic                           frame_start,
    output logic [CODE_W-1:0]              codeword_out,
    output logic [hamming_pkg::DATA_W-1:0] data_out,
    output logic [2:0]                     syndrome,
    output logic                           error_corrected,
    output logic                           word_valid,
    output logic                           resync
);

    import hamming_pkg::*;

    if (CODE_W != hamming_pkg::CODE_W) begin : g_bad_width
        $error("hamming_sipo_decoder: only CODE_W=7 is supported");
    end

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    localparam logic [2:0] LAST_BIT = 3'(CODE_W - 1);

    logic [0:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [CODE_W-1:0] shreg_q, shreg_d;
    logic [CODE_W-1:0] cap_q, cap_d;
    logic              cap_vld_q, cap_vld_d;
    logic              resync_q, resync_d;
    logic [CODE_W-1:0] shifted;

    logic [CODE_W-1:0] cw_out_q;
    logic [DATA_W-1:0] data_q;
    logic [2:0]        syn_q;
    logic              corr_q;
    logic              wv_q;

    logic [DATA_W-1:0] fix_data;
    logic [2:0]        fix_syn;
    logic              fix_corr;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        cap_d     = cap_q;
        cap_vld_d = 1'b0;
        resync_d  = 1'b0;

        // After CODE_W shifts the first bit lands at bit 0 (LSB first) or at
        // the top bit (MSB first).
        if (LSB_FIRST) begin
            shifted = {serial_in, shreg_q[CODE_W-1:1]};
        end else begin
            shifted = {shreg_q[CODE_W-2:0], serial_in};
        end

        if (bit_valid) begin
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        shreg_d = shifted;
                        cnt_d   = 3'd1;
                        state_d = RECV;
                    end
                end
                RECV: begin
                    shreg_d = shifted;
                    // frame_start outranks completion, even on the 7th bit.
                    if (frame_start && (cnt_q != 3'd0)) begin
                        cnt_d    = 3'd1;
                        resync_d = 1'b1;
                    end else if (cnt_q == LAST_BIT) begin
                        cnt_d     = 3'd0;
                        cap_d     = shifted;
                        cap_vld_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            cap_q     <= '0;
            cap_vld_q <= 1'b0;
            resync_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            cap_q     <= cap_d;
            cap_vld_q <= cap_vld_d;
            resync_q  <= resync_d;
        end
    end

    hamming74_correct #(
        .CORRECT_EN (CORRECT_EN)
    ) u_correct (
        .codeword_i        (cap_q),
        .data_o            (fix_data),
        .syndrome_o        (fix_syn),
        .error_corrected_o (fix_corr)
    );

    // Output register: loads the cycle after capture and holds until the next word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cw_out_q <= '0;
            data_q   <= '0;
            syn_q    <= '0;
            corr_q   <= 1'b0;
            wv_q     <= 1'b0;
        end else begin
            wv_q <= cap_vld_q;
            if (cap_vld_q) begin
                cw_out_q <= cap_q;
                data_q   <= fix_data;
                syn_q    <= fix_syn;
                corr_q   <= fix_corr;
            end
        end
    end

    assign codeword_out    = cw_out_q;
    assign data_out        = data_q;
    assign syndrome        = syn_q;
    assign error_corrected = corr_q;
    assign word_valid      = wv_q;
    assign resync          = resync_q;

endmodule

// File: tb/tb_hamming_sipo_decoder.sv
module tb_hamming_sipo_decoder;

    typedef struct packed {
        logic [6:0] cw;
        logic [3:0] data;
        logic [2:0] syn;
        logic       corr;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic       bit_valid;
    logic       frame_start;
    logic [6:0] codeword_out;
    logic [3:0] data_out;
    logic [2:0] syndrome;
    logic       error_corrected;
    logic       word_valid;
    logic       resync;

    int   vectors;
    int   miscompares;
    int   wv_cnt;
    int   resync_cnt;
    int   cyc;
    exp_t exp_q[$];
    int   wv_times[$];

    hamming_sipo_decoder #(
        .CODE_W     (7),
        .LSB_FIRST  (1'b1),
        .CORRECT_EN (1'b1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .serial_in       (serial_in),
        .bit_valid       (bit_valid),
        .frame_start     (frame_start),
        .codeword_out    (codeword_out),
        .data_out        (data_out),
        .syndrome        (syndrome),
        .error_corrected (error_corrected),
        .word_valid      (word_valid),
        .resync          (resync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the syndrome of a Hamming code is the XOR of the
    // positions (1..7) of all set bits.
    function automatic exp_t model(input logic [6:0] cw);
        exp_t       e;
        logic [2:0] s;
        logic [6:0] f;
        s = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (cw[i]) s = s ^ 3'(i + 1);
        end
        f = cw;
        if (s != 3'd0) f[int'(s) - 1] = ~f[int'(s) - 1];
        e.cw   = cw;
        e.data = {f[6], f[5], f[4], f[2]};
        e.syn  = s;
        e.corr = (s != 3'd0);
        return e;
    endfunction

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // Scoreboard: every word_valid pops one expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (resync) resync_cnt++;
            if (word_valid) begin
                exp_t e;
                wv_cnt++;
                wv_times.push_back(cyc);
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word: got cw=%h data=%h with no word expected",
                             codeword_out, data_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({codeword_out, data_out, syndrome, error_corrected} !== e) begin
                        miscompares++;
                        $display("FAIL word: got cw=%h data=%h syn=%0d corr=%b, expected cw=%h data=%h syn=%0d corr=%b",
                                 codeword_out, data_out, syndrome, error_corrected,
                                 e.cw, e.data, e.syn, e.corr);
                    end
                end
            end
        end
    end

    task automatic send_bit(input logic b, input logic fs);
        serial_in   = b;
        frame_start = fs;
        bit_valid   = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends a codeword LSB first; gap_at>0 inserts gap_len idle cycles before that bit.
    task automatic send_word(input logic [6:0] cw, input logic fs, input int gap_at,
                             input int gap_len);
        exp_q.push_back(model(cw));
        for (int i = 0; i < 7; i++) begin
            if (gap_at > 0 && i == gap_at) idle(gap_len);
            send_bit(cw[i], (i == 0) ? fs : 1'b0);
        end
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d words outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        serial_in = 1'b0;
        bit_valid = 1'b0;
        frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({codeword_out, data_out, syndrome, error_corrected, word_valid, resync} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {codeword_out, data_out, syndrome, error_corrected, word_valid, resync});
        end
        rst = 1'b0;
        idle(2);
        vectors++;
        if ({codeword_out, data_out, syndrome, error_corrected, word_valid, resync} !== 17'd0) begin
            miscompares++;
            $display("FAIL post_reset_outputs: got %h expected 0",
                     {codeword_out, data_out, syndrome, error_corrected, word_valid, resync});
        end
    endtask

    task automatic test_clean_word();
        send_word(7'h55, 1'b1, 0, 0);
        bit_valid = 1'b0;
        vectors++;
        if (word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: got word_valid=%b expected 0", word_valid);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({word_valid, data_out, syndrome, error_corrected} !== {1'b1, 4'hB, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL clean_word: got wv=%b data=%h syn=%0d corr=%b expected 1 b 0 0",
                     word_valid, data_out, syndrome, error_corrected);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({word_valid, data_out} !== {1'b0, 4'hB}) begin
            miscompares++;
            $display("FAIL strobe_hold: got wv=%b data=%h expected 0 b", word_valid, data_out);
        end
        drain("clean");
    endtask

    task automatic test_corrected_word();
        send_word(7'h45, 1'b1, 0, 0);
        idle(2);
        vectors++;
        if ({codeword_out, data_out, syndrome, error_corrected} !== {7'h45, 4'hB, 3'd5, 1'b1}) begin
            miscompares++;
            $display("FAIL corrected_word: got cw=%h data=%h syn=%0d corr=%b expected 45 b 5 1",
                     codeword_out, data_out, syndrome, error_corrected);
        end
        drain("corrected");
    endtask

    task automatic test_back_to_back();
        int base_wv;
        int base_rs;
        base_wv = wv_times.size();
        base_rs = resync_cnt;
        send_word(encode(4'h3), 1'b1, 0, 0);
        send_word(encode(4'hC) ^ 7'h08, 1'b0, 0, 0);
        send_word(encode(4'h9), 1'b0, 0, 0);
        idle(4);
        drain("b2b");
        vectors++;
        if (wv_times.size() - base_wv != 3) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d words expected 3", wv_times.size() - base_wv);
        end else begin
            for (int i = 1; i < 3; i++) begin
                vectors++;
                if (wv_times[base_wv + i] - wv_times[base_wv + i - 1] != 7) begin
                    miscompares++;
                    $display("FAIL b2b_spacing: got %0d cycles expected 7",
                             wv_times[base_wv + i] - wv_times[base_wv + i - 1]);
                end
            end
        end
        vectors++;
        if (resync_cnt != base_rs) begin
            miscompares++;
            $display("FAIL b2b_resync: got %0d pulses expected 0", resync_cnt - base_rs);
        end
    endtask

    task automatic test_resync();
        logic [6:0] cw;
        int         base_wv;
        int         base_rs;
        base_wv = wv_cnt;
        base_rs = resync_cnt;
        cw = encode(4'h6);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        exp_q.push_back(model(cw));
        send_bit(cw[0], 1'b1);
        vectors++;
        if (resync !== 1'b1) begin
            miscompares++;
            $display("FAIL resync_pulse: got %b expected 1", resync);
        end
        for (int i = 1; i < 7; i++) send_bit(cw[i], 1'b0);
        idle(3);
        drain("resync");
        vectors++;
        if (wv_cnt - base_wv != 1 || resync_cnt - base_rs != 1) begin
            miscompares++;
            $display("FAIL resync_counts: got words=%0d pulses=%0d expected 1 1",
                     wv_cnt - base_wv, resync_cnt - base_rs);
        end
        // frame_start on the 7th bit wins: fragment dropped, new word starts.
        base_wv = wv_cnt;
        base_rs = resync_cnt;
        cw = encode(4'hA);
        for (int i = 0; i < 6; i++) send_bit(1'b1, (i == 0));
        exp_q.push_back(model(cw));
        for (int i = 0; i < 7; i++) send_bit(cw[i], (i == 0));
        idle(3);
        drain("resync7");
        vectors++;
        if (wv_cnt - base_wv != 1 || resync_cnt - base_rs != 1) begin
            miscompares++;
            $display("FAIL resync7_counts: got words=%0d pulses=%0d expected 1 1",
                     wv_cnt - base_wv, resync_cnt - base_rs);
        end
    endtask

    task automatic test_gap();
        send_word(encode(4'h5) ^ 7'h40, 1'b1, 3, 5);
        idle(2);
        vectors++;
        if ({data_out, syndrome} !== {4'h5, 3'd7}) begin
            miscompares++;
            $display("FAIL gap_word: got data=%h syn=%0d expected 5 7", data_out, syndrome);
        end
        drain("gap");
    endtask

    task automatic test_single_errors();
        logic [3:0] d;
        for (int k = 0; k < 3; k++) begin
            d = 4'($urandom_range(0, 15));
            for (int f = -1; f < 7; f++) begin
                logic [6:0] cw;
                cw = encode(d);
                if (f >= 0) cw[f] = ~cw[f];
                send_word(cw, (k == 0 && f == -1), 0, 0);
            end
        end
        idle(3);
        drain("single_err");
    endtask

    task automatic test_async_reset();
        int base_wv;
        logic [6:0] cw;
        cw = encode(4'hE);
        for (int i = 0; i < 4; i++) send_bit(cw[i], (i == 0));
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({codeword_out, data_out, syndrome, error_corrected, word_valid, resync} !== 17'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected 0",
                     {codeword_out, data_out, syndrome, error_corrected, word_valid, resync});
        end
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        base_wv = wv_cnt;
        for (int i = 0; i < 10; i++) send_bit(i[0], 1'b0);
        idle(3);
        vectors++;
        if (wv_cnt != base_wv || codeword_out !== 7'd0) begin
            miscompares++;
            $display("FAIL ignore_after_reset: got words=%0d cw=%h expected 0 0",
                     wv_cnt - base_wv, codeword_out);
        end
        send_word(encode(4'h7), 1'b1, 0, 0);
        idle(3);
        drain("after_reset");
        vectors++;
        if (wv_cnt - base_wv != 1) begin
            miscompares++;
            $display("FAIL after_reset_count: got %0d words expected 1", wv_cnt - base_wv);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        wv_cnt      = 0;
        resync_cnt  = 0;
        cyc         = 0;
        test_reset();
        test_clean_word();
        test_corrected_word();
        test_back_to_back();
        test_resync();
        test_gap();
        test_single_errors();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
